// File: rtl/shift_arbiter.sv
// rtl/shift_arbiter.sv - round-robin arbiter/sequencer for a shared 8-bit shifter
// Optional macro SHIFT_ARB_BYPASS_EN: zero-amount operations complete at the grant edge.
module shift_arbiter #(
    parameter int SHIFT_LATENCY = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] REQ,
    input  logic [7:0] DATA1_0,
    input  logic [7:0] DATA1_1,
    input  logic [7:0] DATA2_0,
    input  logic [7:0] DATA2_1,
    output logic [1:0] GNT,
    output logic [1:0] DONE,
    output logic [7:0] RESULT,
    output logic       BUSY,
    output logic [7:0] SH_DATA1,
    output logic [7:0] SH_DATA2,
    input  logic [7:0] SH_RESULT
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] CNT_LOAD = 3'(SHIFT_LATENCY - 1);

    state_t     state, state_n;
    logic [2:0] cnt, cnt_n;
    logic [1:0] gnt_n, done_n;
    logic [7:0] result_n, sh_data1_n, sh_data2_n;
    logic       last, last_n;

    logic       win;
    logic [1:0] win_oh;
    logic [7:0] win_data1, win_data2;
    logic       bypass;

    // last == 1 means client 1 was served most recently, so client 0 wins a tie
    assign win       = (REQ == 2'b10) || ((REQ == 2'b11) && !last);
    assign win_oh    = win ? 2'b10 : 2'b01;
    assign win_data1 = win ? DATA1_1 : DATA1_0;
    assign win_data2 = win ? DATA2_1 : DATA2_0;

`ifdef SHIFT_ARB_BYPASS_EN
    assign bypass = (win_data2[6:0] == 7'd0);
`else
    assign bypass = 1'b0;
`endif

    assign BUSY = (state != S_IDLE);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= S_IDLE;
            cnt      <= 3'd0;
            GNT      <= 2'b00;
            DONE     <= 2'b00;
            RESULT   <= 8'h00;
            SH_DATA1 <= 8'h00;
            SH_DATA2 <= 8'h00;
            last     <= 1'b1;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            GNT      <= gnt_n;
            DONE     <= done_n;
            RESULT   <= result_n;
            SH_DATA1 <= sh_data1_n;
            SH_DATA2 <= sh_data2_n;
            last     <= last_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        gnt_n      = GNT;
        done_n     = DONE;
        result_n   = RESULT;
        sh_data1_n = SH_DATA1;
        sh_data2_n = SH_DATA2;
        last_n     = last;
        case (state)
            S_IDLE: begin
                if (REQ != 2'b00) begin
                    gnt_n = win_oh;
                    if (bypass) begin
                        result_n = win_data1;
                        done_n   = win_oh;
                        last_n   = win;
                        state_n  = S_DONE;
                    end else begin
                        sh_data1_n = win_data1;
                        sh_data2_n = win_data2;
                        cnt_n      = CNT_LOAD;
                        state_n    = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt != 3'd0) begin
                    cnt_n = cnt - 3'd1;
                end else begin
                    result_n = SH_RESULT;
                    done_n   = GNT;
                    last_n   = GNT[1];
                    state_n  = S_DONE;
                end
            end
            S_DONE: begin
                gnt_n   = 2'b00;
                done_n  = 2'b00;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule
